wb_shared_bus: RTL and testbench

- Parametrised Wishbone (classic) interconnect connecting M_COUNT bus masters to S_COUNT slaves.
- Successor to the current single-master/single-slave crossbar in the top-level SoC.
- Provides round-robin arbitration, mask/base address decoding, and an internal error responder for unmapped addresses.
- Sits between the CPU/DMA masters and the peripherals (UART, RAM, timers).

---
 rtl/wb_shared_bus_pkg.sv | 47 ++++
 rtl/wb_shared_bus_arb.sv | 96 +++++++++
 rtl/wb_shared_bus.sv | 189 ++++++++++++++++++
 tb/tb_wb_shared_bus.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_shared_bus_pkg.sv
// wb_shared_bus_pkg: shared types and helpers for the wb_shared_bus interconnect.
//   state_t  : arbitration state (IDLE, OWNED)
//   dec_t    : decode result (hit flag plus slave index)
//   idx_w()  : index width helper, never narrower than one bit
//   decode() : mask/base address decoder, lowest matching slave index wins
package wb_shared_bus_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Decoder works on fixed maximum widths; callers zero-extend into these.
  localparam int MAX_S      = 16;
  localparam int MAX_ADR_W  = 64;
  localparam int MAX_SIDX_W = 4;

  typedef struct packed {
    logic                  hit;
    logic [MAX_SIDX_W-1:0] idx;
  } dec_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan from the top down so the lowest matching index is the last one written.
  function automatic dec_t decode(input logic [MAX_ADR_W-1:0]       adr,
                                  input logic [MAX_S*MAX_ADR_W-1:0] base,
                                  input logic [MAX_S*MAX_ADR_W-1:0] mask,
                                  input int                         count);
    dec_t res;
    res.hit = 1'b0;
    res.idx = 4'd0;
    for (int i = MAX_S - 1; i >= 0; i--) begin
      if ((i < count) &&
          ((adr & mask[i*MAX_ADR_W +: MAX_ADR_W]) == base[i*MAX_ADR_W +: MAX_ADR_W])) begin
        res.hit = 1'b1;
        res.idx = MAX_SIDX_W'(i);
      end else begin
        res.hit = res.hit;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_shared_bus_arb.sv
// wb_rr_arbiter: round-robin bus arbiter with registered one-hot grant.
//   clock, reset : clock and asynchronous active-low reset
//   req          : per-master request (master m_cyc)
//   gnt          : registered one-hot grant, zero while idle
//   owner        : index of the current owner (valid while busy)
//   busy         : high while the bus is owned
// The owner holds the bus until its request drops; the pointer then moves
// to owner+1 and one idle cycle passes before the next grant.
module wb_rr_arbiter
  import wb_shared_bus_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy
);

  state_t        state_r, state_s;
  logic [N-1:0]  gnt_r, gnt_s;
  logic [IW-1:0] owner_r, owner_s;
  logic [IW-1:0] ptr_r, ptr_s;
  logic [IW-1:0] pick_idx_s;
  logic          pick_found_s;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found_s && req[(int'(ptr_r) + k) % N]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'((int'(ptr_r) + k) % N);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state logic: grant from IDLE, release from OWNED.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_s             = OWNED;
          gnt_s               = '0;
          gnt_s[pick_idx_s]   = 1'b1;
          owner_s             = pick_idx_s;
        end else begin
          gnt_s = '0;
        end
      end
      OWNED: begin
        if (!req[owner_r]) begin
          state_s = IDLE;
          gnt_s   = '0;
          ptr_s   = (owner_r == IW'(N - 1)) ? IW'(0) : owner_r + IW'(1);
        end else begin
          state_s = OWNED;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      owner_r <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = (state_r == OWNED);

endmodule

// File: rtl/wb_shared_bus.sv
// wb_shared_bus: Wishbone classic shared-bus interconnect, M_COUNT masters to
// S_COUNT slaves, round-robin arbitration, mask/base decode, internal error
// responder for unmapped addresses.
//   clock, reset                 : clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we/m_adr/
//   m_dat_w/m_sel                : packed master requests
//   m_ack/m_err/m_dat_r          : per-master responses (owner only)
//   s_cyc/s_stb/s_we             : per-slave controls (matched slave only)
//   s_adr/s_dat_w/s_sel          : shared slave request fields from the owner
//   s_ack/s_err/s_dat_r          : per-slave responses
//   gnt                          : one-hot current owner, zero when idle
// Optional macro WB_SHARED_BUS_TIMEOUT_EN adds a watchdog that answers a
// stalled beat with m_err after TIMEOUT_CYCLES cycles without ack/err.
module wb_shared_bus
  import wb_shared_bus_pkg::*;
#(
  parameter  int                           M_COUNT        = 2,
  parameter  int                           S_COUNT        = 2,
  parameter  int                           ADR_WIDTH      = 32,
  parameter  int                           DAT_WIDTH      = 32,
  parameter  logic [S_COUNT*ADR_WIDTH-1:0] S_BASE         = '0,
  parameter  logic [S_COUNT*ADR_WIDTH-1:0] S_MASK         = '0,
  parameter  int                           TIMEOUT_CYCLES = 255,
  localparam int                           SEL_WIDTH      = DAT_WIDTH / 8,
  localparam int                           MIDX_W         = idx_w(M_COUNT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [M_COUNT-1:0]           m_cyc,
  input  logic [M_COUNT-1:0]           m_stb,
  input  logic [M_COUNT-1:0]           m_we,
  input  logic [M_COUNT*ADR_WIDTH-1:0] m_adr,
  input  logic [M_COUNT*DAT_WIDTH-1:0] m_dat_w,
  input  logic [M_COUNT*SEL_WIDTH-1:0] m_sel,
  output logic [M_COUNT-1:0]           m_ack,
  output logic [M_COUNT-1:0]           m_err,
  output logic [M_COUNT*DAT_WIDTH-1:0] m_dat_r,
  output logic [S_COUNT-1:0]           s_cyc,
  output logic [S_COUNT-1:0]           s_stb,
  output logic [S_COUNT-1:0]           s_we,
  output logic [ADR_WIDTH-1:0]         s_adr,
  output logic [DAT_WIDTH-1:0]         s_dat_w,
  output logic [SEL_WIDTH-1:0]         s_sel,
  input  logic [S_COUNT-1:0]           s_ack,
  input  logic [S_COUNT-1:0]           s_err,
  input  logic [S_COUNT*DAT_WIDTH-1:0] s_dat_r,
  output logic [M_COUNT-1:0]           gnt
);

  logic [M_COUNT-1:0]       gnt_s;
  logic [MIDX_W-1:0]        owner_s;
  logic                     busy_s;
  logic                     own_cyc_s, own_stb_s, own_we_s;
  logic [ADR_WIDTH-1:0]     own_adr_s;
  logic [DAT_WIDTH-1:0]     own_dat_s;
  logic [SEL_WIDTH-1:0]     own_sel_s;
  logic [MAX_ADR_W-1:0]     adr_wide_s;
  logic [MAX_S*MAX_ADR_W-1:0] base_wide_s, mask_wide_s;
  dec_t                     dec_s;
  logic                     sl_ack_s, sl_err_s;
  logic [DAT_WIDTH-1:0]     sl_dat_s;
  logic                     route_s;
  logic                     to_fire_s;
  logic                     err_pend_r;

  wb_rr_arbiter #(.N(M_COUNT)) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (m_cyc),
    .gnt   (gnt_s),
    .owner (owner_s),
    .busy  (busy_s)
  );

  assign gnt = gnt_s;

  // Owner request mux (AND-OR); own_cyc_s drops as soon as the owner releases.
  always_comb begin
    logic sel_j;
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    own_we_s  = 1'b0;
    own_adr_s = '0;
    own_dat_s = '0;
    own_sel_s = '0;
    sel_j     = 1'b0;
    for (int j = 0; j < M_COUNT; j++) begin
      sel_j     = busy_s && (owner_s == MIDX_W'(j));
      own_cyc_s = own_cyc_s | (m_cyc[j] & sel_j);
      own_stb_s = own_stb_s | (m_stb[j] & sel_j);
      own_we_s  = own_we_s  | (m_we[j]  & sel_j);
      own_adr_s = own_adr_s | (m_adr[j*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{sel_j}});
      own_dat_s = own_dat_s | (m_dat_w[j*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{sel_j}});
      own_sel_s = own_sel_s | (m_sel[j*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{sel_j}});
    end
  end

  // Address decode of the owner's address against the slave windows.
  always_comb begin
    adr_wide_s  = '0;
    base_wide_s = '0;
    mask_wide_s = '0;
    adr_wide_s[ADR_WIDTH-1:0] = own_adr_s;
    for (int i = 0; i < S_COUNT; i++) begin
      base_wide_s[i*MAX_ADR_W +: ADR_WIDTH] = S_BASE[i*ADR_WIDTH +: ADR_WIDTH];
      mask_wide_s[i*MAX_ADR_W +: ADR_WIDTH] = S_MASK[i*ADR_WIDTH +: ADR_WIDTH];
    end
    dec_s = decode(adr_wide_s, base_wide_s, mask_wide_s, S_COUNT);
  end

  // Raw response of the matched slave, before any watchdog override.
  always_comb begin
    logic hit_i;
    sl_ack_s = 1'b0;
    sl_err_s = 1'b0;
    sl_dat_s = '0;
    hit_i    = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      hit_i    = own_cyc_s && dec_s.hit && (dec_s.idx == MAX_SIDX_W'(i));
      sl_ack_s = sl_ack_s | (s_ack[i] & hit_i);
      sl_err_s = sl_err_s | (s_err[i] & hit_i);
      sl_dat_s = sl_dat_s | (s_dat_r[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{hit_i}});
    end
  end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  logic [31:0] to_cnt_r;

  assign to_fire_s = own_cyc_s && own_stb_s && (to_cnt_r >= 32'(TIMEOUT_CYCLES));

  // Watchdog: counts consecutive stalled strobe cycles of a mapped beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= 32'd0;
    end else if (to_fire_s) begin
      to_cnt_r <= 32'd0;
    end else if (own_cyc_s && own_stb_s && dec_s.hit && !sl_ack_s && !sl_err_s) begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end else begin
      to_cnt_r <= 32'd0;
    end
  end
`else
  assign to_fire_s = 1'b0;
`endif

  // Error responder: one pulse per unmapped strobe; the !err_pend_r term keeps
  // pulses from running back-to-back, and losing the owner cancels the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_pend_r <= 1'b0;
    end else begin
      err_pend_r <= own_cyc_s && own_stb_s && !dec_s.hit && !err_pend_r;
    end
  end

  assign route_s = own_cyc_s && dec_s.hit && !to_fire_s;

  // Slave-side controls: only the matched slave is selected.
  always_comb begin
    s_cyc = '0;
    s_stb = '0;
    s_we  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_cyc[i] = route_s && (dec_s.idx == MAX_SIDX_W'(i));
      s_stb[i] = s_cyc[i] && own_stb_s;
      s_we[i]  = s_cyc[i] && own_we_s;
    end
    s_adr   = own_adr_s & {ADR_WIDTH{own_cyc_s}};
    s_dat_w = own_dat_s & {DAT_WIDTH{own_cyc_s}};
    s_sel   = own_sel_s & {SEL_WIDTH{own_cyc_s}};
  end

  // Master-side responses: only the live owner sees anything.
  always_comb begin
    logic sel_j;
    m_ack   = '0;
    m_err   = '0;
    m_dat_r = '0;
    sel_j   = 1'b0;
    for (int j = 0; j < M_COUNT; j++) begin
      sel_j    = own_cyc_s && (owner_s == MIDX_W'(j));
      m_ack[j] = sel_j && sl_ack_s && !to_fire_s;
      m_err[j] = sel_j && ((sl_err_s && !to_fire_s) || err_pend_r || to_fire_s);
      m_dat_r[j*DAT_WIDTH +: DAT_WIDTH] = sl_dat_s & {DAT_WIDTH{sel_j}};
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// tb_wb_shared_bus: directed scoreboard bench for wb_shared_bus (2 masters,
// 2 slaves). Stimulus pushes expected master responses into a queue; a
// monitor pops and compares whenever any m_ack/m_err is presented.
module tb_wb_shared_bus;

  localparam int M  = 2;
  localparam int S  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [M-1:0]      m_cyc, m_stb, m_we, m_ack, m_err;
  logic [M*AW-1:0]   m_adr;
  logic [M*DW-1:0]   m_dat_w, m_dat_r;
  logic [M*SW-1:0]   m_sel;
  logic [S-1:0]      s_cyc, s_stb, s_we, s_ack, s_err;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_w;
  logic [SW-1:0]     s_sel;
  logic [S*DW-1:0]   s_dat_r;
  logic [M-1:0]      gnt;

  typedef struct {
    logic [M-1:0]  ack;
    logic [M-1:0]  err;
    int            m;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  wb_shared_bus #(
    .M_COUNT        (M),
    .S_COUNT        (S),
    .ADR_WIDTH      (AW),
    .DAT_WIDTH      (DW),
    .S_BASE         ({32'h1000_0000, 32'h0000_0000}),
    .S_MASK         ({32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock), .reset (reset),
    .m_cyc (m_cyc), .m_stb (m_stb), .m_we (m_we), .m_adr (m_adr),
    .m_dat_w (m_dat_w), .m_sel (m_sel),
    .m_ack (m_ack), .m_err (m_err), .m_dat_r (m_dat_r),
    .s_cyc (s_cyc), .s_stb (s_stb), .s_we (s_we), .s_adr (s_adr),
    .s_dat_w (s_dat_w), .s_sel (s_sel),
    .s_ack (s_ack), .s_err (s_err), .s_dat_r (s_dat_r),
    .gnt (gnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_we[m]  = we;
    m_adr[m*AW +: AW]   = adr;
    m_dat_w[m*DW +: DW] = dat;
    m_sel[m*SW +: SW]   = sel;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = '0; s_err = '0;
  endtask

  task automatic push_exp(input logic [M-1:0] ack, input logic [M-1:0] err,
                          input int m, input logic [DW-1:0] dat);
    exp_t e;
    e.ack = ack; e.err = err; e.m = m; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_all();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every presented response must match the head of the queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset && ((|m_ack) || (|m_err))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: ack=%b err=%b expected no response", m_ack, m_err);
      end else begin
        e = exp_q.pop_front();
        if ((m_ack !== e.ack) || (m_err !== e.err) || (m_dat_r[e.m*DW +: DW] !== e.dat)) begin
          errors++;
          $display("FAIL resp_m%0d: ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                   e.m, m_ack, m_err, m_dat_r[e.m*DW +: DW], e.ack, e.err, e.dat);
        end
      end
    end
  end

  initial begin
    m_adr = '0; m_dat_w = '0; m_sel = '0; s_dat_r = '0;
    do_reset();

    // Reset state
    @(negedge clock);
    check("rst_gnt", gnt, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_m_dat_r", m_dat_r, 0);

    // Master0 read from slave0
    next_cycle();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    @(negedge clock);
    check("t1_req_cycle_gnt", gnt, 0);
    check("t1_req_cycle_stb", s_stb, 0);
    next_cycle();
    @(negedge clock);
    check("t1_gnt", gnt, 2'b01);
    check("t1_s_stb", s_stb, 2'b01);
    check("t1_s_adr", s_adr, 32'h0000_0010);
    next_cycle();
    s_ack = 2'b01;
    s_dat_r[0 +: DW] = 32'hDEAD_BEEF;
    push_exp(2'b01, 2'b00, 0, 32'hDEAD_BEEF);
    next_cycle();
    idle_all();
    next_cycle();
    @(negedge clock);
    check("t1_release_gnt", gnt, 0);

    // Contention from reset: 0 first, idle cycle, then 1, then 0 again
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
    next_cycle();
    @(negedge clock);
    check("t2_first_gnt", gnt, 2'b01);
    next_cycle();
    s_ack = 2'b01;
    s_dat_r[0 +: DW] = 32'h0000_A0A0;
    push_exp(2'b01, 2'b00, 0, 32'h0000_A0A0);
    next_cycle();
    s_ack = 2'b00;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clock);
    check("t2_drop_ack", m_ack, 0);
    next_cycle();
    @(negedge clock);
    check("t2_idle_gnt", gnt, 0);
    next_cycle();
    @(negedge clock);
    check("t2_second_gnt", gnt, 2'b10);
    check("t2_s_adr_m1", s_adr, 32'h0000_0030);
    next_cycle();
    s_ack = 2'b01;
    s_dat_r[0 +: DW] = 32'h0000_B0B1;
    push_exp(2'b10, 2'b00, 1, 32'h0000_B0B1);
    next_cycle();
    s_ack = 2'b00;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    next_cycle();
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clock);
    check("t2_idle2_gnt", gnt, 0);
    next_cycle();
    @(negedge clock);
    check("t2_third_gnt", gnt, 2'b01);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();

    // Master1 write to slave1
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011);
    next_cycle();
    @(negedge clock);
    check("t3_gnt", gnt, 2'b10);
    check("t3_s_stb", s_stb, 2'b10);
    check("t3_s_cyc", s_cyc, 2'b10);
    check("t3_s_we", s_we, 2'b10);
    check("t3_s_dat_w", s_dat_w, 32'h1234_5678);
    check("t3_s_sel", s_sel, 4'b0011);
    next_cycle();
    s_ack = 2'b10;
    s_dat_r[1*DW +: DW] = 32'h5A5A_0001;
    push_exp(2'b10, 2'b00, 1, 32'h5A5A_0001);
    @(negedge clock);
    check("t3_m0_dat_r", m_dat_r[0 +: DW], 0);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();

    // Unmapped access by master0
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    next_cycle();
    @(negedge clock);
    check("t4_gnt", gnt, 2'b01);
    check("t4_no_stb", s_stb, 0);
    check("t4_no_err_in_stb_cycle", m_err, 0);
    push_exp(2'b00, 2'b01, 0, 32'h0);
    next_cycle();
    @(negedge clock);
    check("t4_err_cycle_no_stb", s_stb, 0);
    next_cycle();
    @(negedge clock);
    check("t4_err_single_pulse", m_err, 0);
    next_cycle();
    idle_all();
    @(negedge clock);
    check("t4_err_cancelled", m_err, 0);
    next_cycle();
    next_cycle();

    // Reset in the middle of a beat owned by master1
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    next_cycle();
    @(negedge clock);
    check("t5_gnt", gnt, 2'b10);
    check("t5_s_stb", s_stb, 2'b01);
    next_cycle();
    s_ack = 2'b01;
    s_dat_r[0 +: DW] = 32'hCAFE_0000;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_s_stb", s_stb, 0);
    check("t5_rst_s_cyc", s_cyc, 0);
    check("t5_rst_m_ack", m_ack, 0);
    check("t5_rst_m_dat_r", m_dat_r, 0);
    s_ack = 2'b00;
    @(negedge clock);
    #1;
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    check("t5_post_rst_gnt", gnt, 2'b01);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();

    // Hung slave0
    s_dat_r = '0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'hF);
    next_cycle();
`ifdef WB_SHARED_BUS_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("t6_stall_no_err", m_err, 0);
      check("t6_stall_stb", s_stb, 2'b01);
      next_cycle();
    end
    push_exp(2'b00, 2'b01, 0, 32'h0);
    @(negedge clock);
    check("t6_timeout_stb_dropped", s_stb, 0);
    check("t6_timeout_cyc_dropped", s_cyc, 0);
    next_cycle();
    @(negedge clock);
    check("t6_after_timeout_stb", s_stb, 2'b01);
    check("t6_after_timeout_err", m_err, 0);
`else
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check("t6_hung_no_err", m_err, 0);
      check("t6_hung_stb", s_stb, 2'b01);
      next_cycle();
    end
`endif
    idle_all();
    next_cycle();
    next_cycle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
